// File: rtl/uart_echo_sys.sv
// UART test subsystem: oversampled receiver, transmitter, one FIFO per direction
// and a host/echo routing switch with sticky receive-error flags.

module uart_echo_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end
endmodule

module uart_echo_sys #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int DBIT     = 8,
    parameter int FIFO_AW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    output logic            tx,
    input  logic            mode,
    input  logic            wr,
    input  logic [DBIT-1:0] denv,
    input  logic            rd,
    output logic [DBIT-1:0] drec,
    output logic            rx_empty,
    output logic            tx_full,
    output logic            frm_err,
    output logic            ovf,
    input  logic            clr_err
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NW      = $clog2(DBIT);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // 16x oversampling tick
    logic [CW-1:0] div_cnt_reg;
    logic          tick;
    assign tick = (div_cnt_reg == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) div_cnt_reg <= '0;
        else             div_cnt_reg <= div_cnt_reg + 1'b1;
    end

    logic rx_meta_reg, rx_sync_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    logic            mode_reg;
    logic            rx_push_reg, rx_pop, rx_full;
    logic [DBIT-1:0] rx_head;
    logic            tx_push, tx_pop, tx_empty;
    logic [DBIT-1:0] tx_din, tx_head;
    logic            echo_xfer;
    logic            frm_err_reg, ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) mode_reg <= 1'b0;
        else     mode_reg <= mode;
    end

    // Receiver
    state_t          rx_state_reg;
    logic [3:0]      rx_s_reg;
    logic [NW-1:0]   rx_n_reg;
    logic [DBIT-1:0] rx_b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg <= ST_IDLE;
            rx_s_reg     <= '0;
            rx_n_reg     <= '0;
            rx_b_reg     <= '0;
            rx_push_reg  <= 1'b0;
            frm_err_reg  <= 1'b0;
        end else begin
            rx_push_reg <= 1'b0;
            if (clr_err) frm_err_reg <= 1'b0;
            case (rx_state_reg)
                ST_IDLE: begin
                    rx_s_reg <= '0;
                    if (!rx_sync_reg) rx_state_reg <= ST_START;
                end
                ST_START: if (tick) begin
                    if (rx_s_reg == 4'd7) begin
                        rx_s_reg     <= '0;
                        rx_n_reg     <= '0;
                        rx_state_reg <= rx_sync_reg ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_s_reg <= rx_s_reg + 1'b1;
                    end
                end
                ST_DATA: if (tick) begin
                    if (rx_s_reg == 4'd15) begin
                        rx_s_reg <= '0;
                        rx_b_reg <= {rx_sync_reg, rx_b_reg[DBIT-1:1]};
                        if (rx_n_reg == NW'(DBIT - 1)) rx_state_reg <= ST_STOP;
                        else                           rx_n_reg <= rx_n_reg + 1'b1;
                    end else begin
                        rx_s_reg <= rx_s_reg + 1'b1;
                    end
                end
                ST_STOP: if (tick) begin
                    if (rx_s_reg == 4'd15) begin
                        rx_state_reg <= ST_IDLE;
                        if (rx_sync_reg) rx_push_reg <= 1'b1;
                        else             frm_err_reg <= 1'b1;
                    end else begin
                        rx_s_reg <= rx_s_reg + 1'b1;
                    end
                end
                default: rx_state_reg <= ST_IDLE;
            endcase
        end
    end

    // Routing between host and echo path
    assign echo_xfer = mode_reg && !rx_empty && !tx_full;
    assign rx_pop    = mode_reg ? echo_xfer : rd;
    assign tx_push   = mode_reg ? echo_xfer : wr;
    assign tx_din    = mode_reg ? rx_head : denv;
    assign drec      = rx_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else begin
            if (clr_err) ovf_reg <= 1'b0;
            if (rx_push_reg && rx_full && !rx_pop) ovf_reg <= 1'b1;
        end
    end

    assign frm_err = frm_err_reg;
    assign ovf     = ovf_reg;

    uart_echo_fifo #(.W(DBIT), .AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push(rx_push_reg), .din(rx_b_reg),
        .pop(rx_pop), .dout(rx_head),
        .empty(rx_empty), .full(rx_full)
    );

    uart_echo_fifo #(.W(DBIT), .AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push(tx_push), .din(tx_din),
        .pop(tx_pop), .dout(tx_head),
        .empty(tx_empty), .full(tx_full)
    );

    // Transmitter: reloading straight from the stop bit keeps queued frames gapless.
    state_t          tx_state_reg;
    logic [3:0]      tx_s_reg;
    logic [NW-1:0]   tx_n_reg;
    logic [DBIT-1:0] tx_b_reg;
    logic            tx_reg;

    assign tx_pop = !tx_empty &&
                    ((tx_state_reg == ST_IDLE) ||
                     (tx_state_reg == ST_STOP && tick && tx_s_reg == 4'd15));
    assign tx = tx_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= ST_IDLE;
            tx_s_reg     <= '0;
            tx_n_reg     <= '0;
            tx_b_reg     <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (tx_state_reg)
                ST_IDLE: if (tx_pop) begin
                    tx_reg       <= 1'b0;
                    tx_b_reg     <= tx_head;
                    tx_s_reg     <= '0;
                    tx_state_reg <= ST_START;
                end
                ST_START: if (tick) begin
                    if (tx_s_reg == 4'd15) begin
                        tx_s_reg     <= '0;
                        tx_n_reg     <= '0;
                        tx_reg       <= tx_b_reg[0];
                        tx_state_reg <= ST_DATA;
                    end else begin
                        tx_s_reg <= tx_s_reg + 1'b1;
                    end
                end
                ST_DATA: if (tick) begin
                    if (tx_s_reg == 4'd15) begin
                        tx_s_reg <= '0;
                        tx_b_reg <= tx_b_reg >> 1;
                        if (tx_n_reg == NW'(DBIT - 1)) begin
                            tx_reg       <= 1'b1;
                            tx_state_reg <= ST_STOP;
                        end else begin
                            tx_n_reg <= tx_n_reg + 1'b1;
                            tx_reg   <= tx_b_reg[1];
                        end
                    end else begin
                        tx_s_reg <= tx_s_reg + 1'b1;
                    end
                end
                ST_STOP: if (tick) begin
                    if (tx_s_reg == 4'd15) begin
                        tx_s_reg <= '0;
                        if (tx_pop) begin
                            tx_reg       <= 1'b0;
                            tx_b_reg     <= tx_head;
                            tx_state_reg <= ST_START;
                        end else begin
                            tx_state_reg <= ST_IDLE;
                        end
                    end else begin
                        tx_s_reg <= tx_s_reg + 1'b1;
                    end
                end
                default: tx_state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule
